gray_conv_arbiter: RTL

- Shares one registered binary-to-Gray conversion stage between N requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- One registered output holds the Gray result, the original binary value and the requester ID, with its own valid/ready handshake.
- Sits between the producer blocks (pointer and counter sources) and the consumers that need Gray-coded values.

---
 rtl/gray_conv_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter sharing one registered binary-to-Gray stage
module gray_conv_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gray,
  output logic [W-1:0]     out_bin,
  output logic [IDW-1:0]   out_id,
  output logic [15:0]      conv_count
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant, id_q;
  logic [W-1:0]   gray_q, bin_q, data_g;
  logic [15:0]    cnt_q;
  logic           drain, load;
  // Descending scan so the requester closest above rr_ptr overwrites the rest
  always_comb begin
    int idx;
    idx = 0;
    grant = rr_ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (req_valid[idx]) grant = IDW'(idx);
    end
  end
  assign data_g    = req_data[int'(grant)*W +: W];
  assign drain     = out_valid & out_ready;
  assign load      = (|req_valid) & (~out_valid | out_ready);
  assign req_ready = (load & ~rst) ? (N'(1) << grant) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  always_comb begin
    state_d  = load ? FULL : (drain ? EMPTY : state_q);
    rr_ptr_d = load ? ((grant == IDW'(N - 1)) ? '0 : grant + IDW'(1)) : rr_ptr_q;
  end
  always_comb begin
    out_valid  = state_q == FULL;
    out_gray   = gray_q;
    out_bin    = bin_q;
    out_id     = id_q;
    conv_count = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr_q <= '0;
      gray_q   <= '0;
      bin_q    <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        bin_q  <= data_g;
        gray_q <= data_g ^ (data_g >> 1);
        id_q   <= grant;
      end
      if (drain && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
endmodule
